// File: rtl/sng_lfsr_tx_if.sv
// Operand-load and bit-stream handshake bundle for sng_lfsr_tx.
// The seed-load pair is present only when SNG_SEED_ROT_EN is defined.
interface sng_lfsr_tx_if #(
    parameter int unsigned DATAWD = 8
);
    logic [DATAWD-1:0] iVal;
    logic              iValid;
    logic              oReady;
    logic              oBit;
    logic              oBitValid;
    logic              iBitReady;
    logic              oDone;
    logic              oBusy;
`ifdef SNG_SEED_ROT_EN
    logic              iSeedLd;
    logic [DATAWD-1:0] iSeed;
`endif

    modport slave (
`ifdef SNG_SEED_ROT_EN
        input  iSeedLd, iSeed,
`endif
        input  iVal, iValid, iBitReady,
        output oReady, oBit, oBitValid, oDone, oBusy
    );

    modport master (
`ifdef SNG_SEED_ROT_EN
        output iSeedLd, iSeed,
`endif
        output iVal, iValid, iBitReady,
        input  oReady, oBit, oBitValid, oDone, oBusy
    );
endinterface

// File: rtl/sng_lfsr_tx.sv
// Stochastic number generator: one operand in, 2^DATAWD-1 unipolar bits out with exactly
// iVal ones. Macro SNG_SEED_ROT_EN keeps the LFSR running across bursts and adds seed load.
module sng_lfsr_tx #(
    parameter int unsigned       DATAWD = 8,
    parameter logic [DATAWD-1:0] SEED   = {{(DATAWD-1){1'b0}}, 1'b1}
) (
    input  logic         clk,
    input  logic         rst_n,
    sng_lfsr_tx_if.slave bus
);
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [DATAWD-1:0] ONE_C    = {{(DATAWD-1){1'b0}}, 1'b1};
    localparam logic [DATAWD-1:0] ZERO_C   = {DATAWD{1'b0}};
    localparam logic [DATAWD-1:0] CNT_LAST = {{(DATAWD-1){1'b1}}, 1'b0};

    // Fibonacci feedback mask, bit k set for polynomial term x^(k+1).
    function automatic logic [DATAWD-1:0] tap_mask();
        logic [31:0] m;
        case (DATAWD)
            32'd4:   m = 32'h0000_000C;
            32'd5:   m = 32'h0000_0014;
            32'd6:   m = 32'h0000_0030;
            32'd7:   m = 32'h0000_0060;
            32'd8:   m = 32'h0000_00B8;
            32'd9:   m = 32'h0000_0110;
            32'd10:  m = 32'h0000_0240;
            32'd11:  m = 32'h0000_0500;
            32'd12:  m = 32'h0000_0829;
            32'd16:  m = 32'h0000_D008;
            default: m = 32'h0000_00B8;
        endcase
        return m[DATAWD-1:0];
    endfunction

    function automatic logic [DATAWD-1:0] nonzero(input logic [DATAWD-1:0] s);
        logic [DATAWD-1:0] r;
        if (s == ZERO_C) begin
            r = ONE_C;
        end else begin
            r = s;
        end
        return r;
    endfunction

    localparam logic [DATAWD-1:0] TAPS    = tap_mask();
    localparam logic [DATAWD-1:0] SEED_NZ = (SEED == ZERO_C) ? ONE_C : SEED;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATAWD-1:0] r_lfsr;
    logic [DATAWD-1:0] r_val;
    logic [DATAWD-1:0] r_cnt;
    logic              r_done;
    logic              w_load;
    logic              w_xfer;
    logic              w_last;
    logic              w_ready;
    logic              w_bit_valid;
    logic              w_busy;
    logic [DATAWD-1:0] w_lfsr_step;

    assign w_load      = (r_state == ST_IDLE) && bus.iValid;
    assign w_xfer      = (r_state == ST_RUN) && bus.iBitReady;
    assign w_last      = w_xfer && (r_cnt == CNT_LAST);
    assign w_lfsr_step = {r_lfsr[DATAWD-2:0], ^(r_lfsr & TAPS)};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a burst ends on the transfer of its last bit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the state register.
    always_comb begin
        w_ready     = 1'b0;
        w_bit_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: w_ready = 1'b1;
            ST_RUN: begin
                w_bit_valid = 1'b1;
                w_busy      = 1'b1;
            end
            default: w_ready = 1'b0;
        endcase
    end

    assign bus.oReady    = w_ready;
    assign bus.oBitValid = w_bit_valid;
    assign bus.oBusy     = w_busy;
    // The LFSR visits every nonzero state once per burst, so exactly r_val states satisfy this.
    assign bus.oBit      = w_bit_valid & (r_val >= r_lfsr);
    assign bus.oDone     = r_done;

    // Operand buffer, bit counter, done pulse and LFSR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val  <= ZERO_C;
            r_cnt  <= ZERO_C;
            r_done <= 1'b0;
            r_lfsr <= SEED_NZ;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_val <= bus.iVal;
                r_cnt <= ZERO_C;
            end else if (w_xfer) begin
                r_cnt <= r_cnt + ONE_C;
            end
`ifdef SNG_SEED_ROT_EN
            if ((r_state == ST_IDLE) && bus.iSeedLd) begin
                r_lfsr <= nonzero(bus.iSeed);
            end else if (w_xfer) begin
                r_lfsr <= w_lfsr_step;
            end
`else
            if (w_load) begin
                r_lfsr <= SEED_NZ;
            end else if (w_xfer) begin
                r_lfsr <= w_lfsr_step;
            end
`endif
        end
    end
endmodule

// File: tb/tb_sng_lfsr_tx.sv
// Directed bench for sng_lfsr_tx (DATAWD=8, SEED=1); seed-load steps build only with
// SNG_SEED_ROT_EN. LFSR order from seed 1: 01 02 04 08 11 23 47 8E 1C ...
module tb_sng_lfsr_tx;
    logic clk;
    logic rst_n;

    sng_lfsr_tx_if #(.DATAWD(8)) bus ();

    sng_lfsr_tx #(.DATAWD(8), .SEED(8'h01)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int           b_ones, b_xfers, b_cyc, b_dones, b_early, b_unstable, b_first_valid, b_busy_bad;
    logic [254:0] b_seq;
    logic [254:0] seq_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One operand burst; stall_pct>0 deasserts iBitReady at random, hold_new re-offers 200 during RUN.
    task automatic burst(input logic [7:0] val, input int stall_pct, input bit hold_new);
        bit   prev_stall;
        logic prev_bit;
        logic rdy;
        b_ones = 0; b_xfers = 0; b_cyc = 0; b_dones = 0; b_early = 0;
        b_unstable = 0; b_first_valid = 0; b_busy_bad = 0; b_seq = '0;
        prev_stall = 1'b0; prev_bit = 1'b0;
        @(negedge clk);
        check("ready_before_load", {31'd0, bus.oReady}, 32'd1);
        bus.iVal = val; bus.iValid = 1'b1; bus.iBitReady = 1'b0;
        @(negedge clk);
        b_cyc = 1;
        b_first_valid = bus.oBitValid;
        if (hold_new) bus.iVal = 8'd200;
        else          bus.iValid = 1'b0;
        while (b_cyc < 3000) begin
            if (bus.oDone) begin
                b_dones++;
                if (b_xfers != 255) b_early++;
            end
            if (bus.oReady) break;
            if (bus.oBusy !== bus.oBitValid) b_busy_bad++;
            if (prev_stall && (bus.oBit !== prev_bit)) b_unstable++;
            rdy = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
            bus.iBitReady = rdy;
            if (bus.oBitValid && rdy) begin
                if (b_xfers < 255) b_seq[b_xfers] = bus.oBit;
                b_ones += int'(bus.oBit);
                b_xfers++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = bus.oBitValid;
                prev_bit   = bus.oBit;
            end
            @(negedge clk);
            b_cyc++;
        end
        bus.iValid = 1'b0; bus.iBitReady = 1'b0;
        @(negedge clk);
        if (bus.oDone) b_dones++;
    endtask

    int x, diff, viol, late_done;

    initial begin
        rst_n = 1'b0;
        bus.iVal = 8'd0; bus.iValid = 1'b0; bus.iBitReady = 1'b0;
`ifdef SNG_SEED_ROT_EN
        bus.iSeedLd = 1'b0; bus.iSeed = 8'd0;
`endif
        repeat (3) @(negedge clk);
        check("rst_ready",  {31'd0, bus.oReady},    32'd1);
        check("rst_bitvld", {31'd0, bus.oBitValid}, 32'd0);
        check("rst_bit",    {31'd0, bus.oBit},      32'd0);
        check("rst_done",   {31'd0, bus.oDone},     32'd0);
        check("rst_busy",   {31'd0, bus.oBusy},     32'd0);
        rst_n = 1'b1;

        // All-zero operand, consumer always ready.
        burst(8'd0, 0, 1'b0);
        check("v0_ones",     b_ones,        32'd0);
        check("v0_xfers",    b_xfers,       32'd255);
        check("v0_cycles",   b_cyc,         32'd256);
        check("v0_dones",    b_dones,       32'd1);
        check("v0_latency",  b_first_valid, 32'd1);
        check("v0_busy",     b_busy_bad,    32'd0);

        burst(8'd255, 0, 1'b0);
        check("v255_ones",   b_ones,        32'd255);
        burst(8'd128, 0, 1'b0);
        check("v128_ones",   b_ones,        32'd128);
        check("v128_prefix", {23'd0, b_seq[8:0]}, 32'h17F);
        burst(8'd1, 0, 1'b0);
        check("v1_ones",     b_ones,        32'd1);
        check("v1_first",    {31'd0, b_seq[0]}, 32'd1);

        // Random backpressure.
        burst(8'd77, 40, 1'b0);
        check("v77_ones",     b_ones,     32'd77);
        check("v77_xfers",    b_xfers,    32'd255);
        check("v77_dones",    b_dones,    32'd1);
        check("v77_early",    b_early,    32'd0);
        check("v77_unstable", b_unstable, 32'd0);

        // New operand offered during RUN must be ignored; re-offered one reuses the sequence.
        burst(8'd100, 0, 1'b1);
        check("v100_ignore_ones", b_ones, 32'd100);
        seq_a = b_seq;
        burst(8'd200, 0, 1'b0);
        check("v200_ones",   b_ones, 32'd200);
        diff = 0; viol = 0;
        for (int i = 0; i < 255; i++) begin
            if (seq_a[i] !== b_seq[i]) diff++;
            if (seq_a[i] && !b_seq[i]) viol++;
        end
        check("seq_diff_100_200", diff, 32'd100);
        check("seq_monotone",     viol, 32'd0);

        // Asynchronous reset after 100 transfers of operand 50.
        @(negedge clk);
        bus.iVal = 8'd50; bus.iValid = 1'b1; bus.iBitReady = 1'b1;
        @(negedge clk);
        bus.iValid = 1'b0;
        x = 0;
        for (int c = 0; c < 400; c++) begin
            if (bus.oBitValid) x++;
            if (x >= 100) break;
            @(negedge clk);
        end
        #1 rst_n = 1'b0;
        #1;
        check("abort_xfers",  x,                      32'd100);
        check("abort_ready",  {31'd0, bus.oReady},    32'd1);
        check("abort_bitvld", {31'd0, bus.oBitValid}, 32'd0);
        check("abort_busy",   {31'd0, bus.oBusy},     32'd0);
        check("abort_bit",    {31'd0, bus.oBit},      32'd0);
        bus.iBitReady = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        late_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.oDone) late_done++;
        end
        check("abort_no_done", late_done, 32'd0);
        burst(8'd50, 0, 1'b0);
        check("v50_after_rst", b_ones, 32'd50);

`ifdef SNG_SEED_ROT_EN
        // Seed A5 gives states A5 4A 95 ...; against 90 the first bits are 0 1 0.
        @(negedge clk);
        bus.iSeedLd = 1'b1; bus.iSeed = 8'hA5;
        @(negedge clk);
        bus.iSeedLd = 1'b0;
        burst(8'd90, 0, 1'b0);
        check("seed_a5_ones",   b_ones, 32'd90);
        check("seed_a5_prefix", {29'd0, b_seq[2:0]}, 32'd2);
        @(negedge clk);
        bus.iSeedLd = 1'b1; bus.iSeed = 8'h00;
        @(negedge clk);
        bus.iSeedLd = 1'b0;
        burst(8'd1, 0, 1'b0);
        check("seed_zero_ones",  b_ones, 32'd1);
        check("seed_zero_first", {31'd0, b_seq[0]}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
